// File: rtl/switch_pkg.sv
// Shared constants, types and the priority/round-robin pick used by param_switch_router.
package switch_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_ADDR_W    = 16;
  localparam int DEF_DATA_W    = 16;
  localparam int DEF_ROUTE_W   = 4;
  localparam int DEF_DEPTH     = 8;
  localparam int DEF_AE_LVL    = 2;
  localparam int DEF_AF_LVL    = 6;
  localparam int MAX_PORTS     = 16;

  typedef logic [1:0] prio_t;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Scans from ptr upward with wrap; a later candidate only displaces the current
  // pick on strictly higher priority, so ties resolve to the first one after ptr.
  function automatic pick_t rr_prio_pick(
    input logic [MAX_PORTS-1:0]   req,
    input logic [2*MAX_PORTS-1:0] prio,
    input logic [3:0]             ptr,
    input int unsigned            n
  );
    pick_t       r;
    prio_t       best;
    int unsigned idx;
    r    = '0;
    best = '0;
    idx  = 0;
    for (int unsigned k = 0; k < MAX_PORTS; k++) begin
      if (k < n) begin
        idx = (32'(ptr) + k) % n;
        if (req[idx] && (!r.found || prio[2*idx +: 2] > best)) begin
          r.found = 1'b1;
          r.idx   = 4'(idx);
          best    = prio[2*idx +: 2];
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// First-word fall-through queue with registered occupancy flags; head reads as zero when empty.
module router_fifo
  import switch_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AE_LVL = DEF_AE_LVL,
  parameter int AF_LVL = DEF_AF_LVL
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             rdy,
  output logic             empty,
  output logic             ae,
  output logic             af,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             do_push, do_pop;

  // Full blocks a push even when the same cycle pops.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    cnt_nxt = cnt;
    case ({do_push, do_pop})
      2'b10:   cnt_nxt = cnt + 1'b1;
      2'b01:   cnt_nxt = cnt - 1'b1;
      default: cnt_nxt = cnt;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      empty  <= 1'b1;
      ae     <= 1'b1;
      af     <= 1'b0;
      full   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt   <= cnt_nxt;
      empty <= (cnt_nxt == '0);
      ae    <= (cnt_nxt <= CNT_W'(AE_LVL));
      af    <= (cnt_nxt >= CNT_W'(AF_LVL));
      full  <= (cnt_nxt == CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr];
  assign rdy  = ~empty;

endmodule

// File: rtl/param_switch_router.sv
// N-source to N-destination packet router: route table lookup, per-destination
// priority arbitration with round-robin tie-break, and FWFT output queues.
module param_switch_router
  import switch_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ROUTE_W   = DEF_ROUTE_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AE_LVL    = DEF_AE_LVL,
  parameter int AF_LVL    = DEF_AF_LVL
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_PORTS*ADDR_W-1:0]    addr_in,
  input  logic [NUM_PORTS*DATA_W-1:0]    data_in,
  input  logic [NUM_PORTS-1:0]           wr_en,
  output logic [NUM_PORTS-1:0]           data_rcv,
  output logic [NUM_PORTS-1:0]           drop,
  input  logic                           prio_wr,
  input  logic [2*NUM_PORTS-1:0]         prio_val,
  input  logic                           port_en,
  input  logic                           port_wr,
  input  logic [$clog2(NUM_PORTS)-1:0]   port_sel,
  input  logic [ROUTE_W-1:0]             port_addr,
  output logic [NUM_PORTS*ADDR_W-1:0]    addr_out,
  output logic [NUM_PORTS*DATA_W-1:0]    data_out,
  output logic [NUM_PORTS-1:0]           data_rdy,
  input  logic [NUM_PORTS-1:0]           rd_en,
  output logic [NUM_PORTS-1:0]           fifo_empty,
  output logic [NUM_PORTS-1:0]           fifo_ae,
  output logic [NUM_PORTS-1:0]           fifo_af,
  output logic [NUM_PORTS-1:0]           fifo_full
);

  localparam int SEL_W = $clog2(NUM_PORTS);
  localparam int ENT_W = ADDR_W + DATA_W;

  prio_t                  prio_q  [NUM_PORTS];
  logic [ROUTE_W-1:0]     route_q [NUM_PORTS];
  logic [SEL_W-1:0]       rr_ptr  [NUM_PORTS];
  logic [SEL_W-1:0]       dest    [NUM_PORTS];
  logic [SEL_W-1:0]       win     [NUM_PORTS];
  logic [ENT_W-1:0]       push_data [NUM_PORTS];
  logic [ENT_W-1:0]       head    [NUM_PORTS];
  logic [NUM_PORTS-1:0]   routed, push, full_w;
  logic [NUM_PORTS-1:0]   rcv_p0, drop_p0, rcv_p1, drop_p1;
  logic [2*MAX_PORTS-1:0] prio_flat;

  // Stage p0: route lookup, lowest matching destination wins.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      routed[i] = 1'b0;
      dest[i]   = '0;
      for (int d = NUM_PORTS - 1; d >= 0; d--) begin
        if (route_q[d] == addr_in[i*ADDR_W + ADDR_W - 1 -: ROUTE_W]) begin
          routed[i] = 1'b1;
          dest[i]   = SEL_W'(d);
        end
      end
    end
  end

  // A source's request is masked in its data_rcv cycle so one packet is never taken twice.
  always_comb begin
    logic [MAX_PORTS-1:0] req;
    pick_t                pk;
    prio_flat = '0;
    rcv_p0    = '0;
    drop_p0   = '0;
    push      = '0;
    req       = '0;
    pk        = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      prio_flat[2*i +: 2] = prio_q[i];
      if (port_en && wr_en[i] && !rcv_p1[i] && !routed[i]) drop_p0[i] = 1'b1;
    end
    for (int d = 0; d < NUM_PORTS; d++) begin
      req = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (wr_en[i] && !rcv_p1[i] && routed[i] && dest[i] == SEL_W'(d)) req[i] = 1'b1;
      end
      pk      = rr_prio_pick(req, prio_flat, 4'(rr_ptr[d]), NUM_PORTS);
      win[d]  = SEL_W'(pk.idx);
      push[d] = port_en && pk.found && !full_w[d];
      if (push[d]) rcv_p0[win[d]] = 1'b1;
    end
    rcv_p0 = rcv_p0 | drop_p0;
  end

  // Stage p1: registered handshake pulses and configuration state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcv_p1  <= '0;
      drop_p1 <= '0;
      for (int d = 0; d < NUM_PORTS; d++) begin
        prio_q[d]  <= '0;
        route_q[d] <= ROUTE_W'(d);
        rr_ptr[d]  <= '0;
      end
    end else begin
      rcv_p1  <= rcv_p0;
      drop_p1 <= drop_p0;
      if (prio_wr) begin
        for (int i = 0; i < NUM_PORTS; i++) prio_q[i] <= prio_val[2*i +: 2];
      end
      if (port_wr && int'(port_sel) < NUM_PORTS) route_q[port_sel] <= port_addr;
      for (int d = 0; d < NUM_PORTS; d++) begin
        if (push[d]) rr_ptr[d] <= (win[d] == SEL_W'(NUM_PORTS - 1)) ? '0 : win[d] + 1'b1;
      end
    end
  end

  assign data_rcv  = rcv_p1;
  assign drop      = drop_p1;
  assign fifo_full = full_w;

  for (genvar d = 0; d < NUM_PORTS; d++) begin : g_dest
    assign push_data[d] = {addr_in[win[d]*ADDR_W +: ADDR_W], data_in[win[d]*DATA_W +: DATA_W]};

    router_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH),
      .AE_LVL(AE_LVL),
      .AF_LVL(AF_LVL)
    ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push[d]),
      .push_data(push_data[d]),
      .pop      (rd_en[d]),
      .head     (head[d]),
      .rdy      (data_rdy[d]),
      .empty    (fifo_empty[d]),
      .ae       (fifo_ae[d]),
      .af       (fifo_af[d]),
      .full     (full_w[d])
    );

    assign addr_out[d*ADDR_W +: ADDR_W] = head[d][ENT_W-1 -: ADDR_W];
    assign data_out[d*DATA_W +: DATA_W] = head[d][DATA_W-1:0];
  end

endmodule

// File: tb/tb_param_switch_router.sv
// Directed and randomized bench for param_switch_router against a queue-based reference model.
module tb_param_switch_router;

  localparam int N     = 4;
  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int RW    = 4;
  localparam int DEPTH = 8;
  localparam int AE    = 2;
  localparam int AF    = 6;
  localparam int SW    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N*AW-1:0] addr_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    wr_en, data_rcv, drop;
  logic            prio_wr;
  logic [2*N-1:0]  prio_val;
  logic            port_en, port_wr;
  logic [SW-1:0]   port_sel;
  logic [RW-1:0]   port_addr;
  logic [N*AW-1:0] addr_out;
  logic [N*DW-1:0] data_out;
  logic [N-1:0]    data_rdy, rd_en, fifo_empty, fifo_ae, fifo_af, fifo_full;

  param_switch_router #(
    .NUM_PORTS(N), .ADDR_W(AW), .DATA_W(DW), .ROUTE_W(RW),
    .DEPTH(DEPTH), .AE_LVL(AE), .AF_LVL(AF)
  ) dut (
    .clk(clk), .reset(reset), .addr_in(addr_in), .data_in(data_in), .wr_en(wr_en),
    .data_rcv(data_rcv), .drop(drop), .prio_wr(prio_wr), .prio_val(prio_val),
    .port_en(port_en), .port_wr(port_wr), .port_sel(port_sel), .port_addr(port_addr),
    .addr_out(addr_out), .data_out(data_out), .data_rdy(data_rdy), .rd_en(rd_en),
    .fifo_empty(fifo_empty), .fifo_ae(fifo_ae), .fifo_af(fifo_af), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  typedef logic [AW+DW-1:0] ent_t;
  ent_t mq [N][$];
  int   prio_m [N];
  int   rt_m   [N];
  int   rr_m   [N];
  bit   rcv_m  [N];
  bit   drop_m [N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < N; d++) begin
      mq[d].delete();
      prio_m[d] = 0;
      rt_m[d]   = d;
      rr_m[d]   = 0;
      rcv_m[d]  = 1'b0;
      drop_m[d] = 1'b0;
    end
  endtask

  // One clock of the switch's rules, evaluated on the inputs currently applied.
  task automatic model_step();
    int route [N];
    bit eff   [N];
    bit acc   [N];
    bit drp   [N];
    int wsrc  [N];
    for (int i = 0; i < N; i++) begin
      int tag;
      eff[i]   = wr_en[i] && !rcv_m[i];
      tag      = int'(addr_in[i*AW + AW - 1 -: RW]);
      route[i] = -1;
      for (int d = 0; d < N; d++) if (route[i] < 0 && rt_m[d] == tag) route[i] = d;
      acc[i] = 1'b0;
      drp[i] = port_en && eff[i] && (route[i] < 0);
    end
    for (int d = 0; d < N; d++) begin
      int maxp;
      maxp    = -1;
      wsrc[d] = -1;
      for (int i = 0; i < N; i++)
        if (eff[i] && route[i] == d && prio_m[i] > maxp) maxp = prio_m[i];
      if (maxp >= 0 && port_en && mq[d].size() < DEPTH) begin
        for (int k = 0; k < N; k++) begin
          int s;
          s = (rr_m[d] + k) % N;
          if (wsrc[d] < 0 && eff[s] && route[s] == d && prio_m[s] == maxp) wsrc[d] = s;
        end
      end
    end
    for (int d = 0; d < N; d++) begin
      if (rd_en[d] && mq[d].size() > 0) void'(mq[d].pop_front());
      if (wsrc[d] >= 0) begin
        mq[d].push_back({addr_in[wsrc[d]*AW +: AW], data_in[wsrc[d]*DW +: DW]});
        acc[wsrc[d]] = 1'b1;
        rr_m[d] = (wsrc[d] + 1) % N;
      end
    end
    for (int i = 0; i < N; i++) begin
      rcv_m[i]  = acc[i] || drp[i];
      drop_m[i] = drp[i];
    end
    if (prio_wr) for (int i = 0; i < N; i++) prio_m[i] = int'(prio_val[2*i +: 2]);
    if (port_wr) rt_m[port_sel] = int'(port_addr);
  endtask

  task automatic check_outputs();
    for (int d = 0; d < N; d++) begin
      int   sz;
      ent_t hd;
      sz = mq[d].size();
      hd = (sz > 0) ? mq[d][0] : '0;
      chk($sformatf("data_rcv[%0d]", d), 32'(data_rcv[d]), 32'(rcv_m[d]));
      chk($sformatf("drop[%0d]", d), 32'(drop[d]), 32'(drop_m[d]));
      chk($sformatf("data_rdy[%0d]", d), 32'(data_rdy[d]), 32'(sz > 0));
      chk($sformatf("fifo_empty[%0d]", d), 32'(fifo_empty[d]), 32'(sz == 0));
      chk($sformatf("fifo_ae[%0d]", d), 32'(fifo_ae[d]), 32'(sz <= AE));
      chk($sformatf("fifo_af[%0d]", d), 32'(fifo_af[d]), 32'(sz >= AF));
      chk($sformatf("fifo_full[%0d]", d), 32'(fifo_full[d]), 32'(sz == DEPTH));
      chk($sformatf("data_out[%0d]", d), 32'(data_out[d*DW +: DW]), 32'(hd[DW-1:0]));
      chk($sformatf("addr_out[%0d]", d), 32'(addr_out[d*AW +: AW]), 32'(hd[AW+DW-1 -: AW]));
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic put(input int s, input logic [AW-1:0] a, input logic [DW-1:0] dv);
    addr_in[s*AW +: AW] = a;
    data_in[s*DW +: DW] = dv;
    wr_en[s] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [RW-1:0] tags [6];
    tags = '{4'h0, 4'h1, 4'h2, 4'h3, 4'hF, 4'h7};

    reset = 1'b0; addr_in = '0; data_in = '0; wr_en = '0; prio_wr = 1'b0; prio_val = '0;
    port_en = 1'b1; port_wr = 1'b0; port_sel = '0; port_addr = '0; rd_en = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;

    // Basic accept into destination 2.
    put(0, 16'h2ABC, 16'h1234);
    step();
    chk("t1_rcv0", 32'(data_rcv[0]), 32'd1);
    chk("t1_rdy2", 32'(data_rdy[2]), 32'd1);
    chk("t1_dout2", 32'(data_out[2*DW +: DW]), 32'h1234);
    chk("t1_empty2", 32'(fifo_empty[2]), 32'd0);
    chk("t1_ae2", 32'(fifo_ae[2]), 32'd1);
    wr_en[0] = 1'b0;
    step();
    chk("t1_rcv0_pulse", 32'(data_rcv[0]), 32'd0);
    rd_en[2] = 1'b1;
    step();
    rd_en[2] = 1'b0;
    chk("t1_drained", 32'(fifo_empty[2]), 32'd1);

    // Priority: source 3 (prio 2) beats source 1 (prio 1) for destination 0.
    prio_val = 8'b10_00_01_00; prio_wr = 1'b1;
    step();
    prio_wr = 1'b0;
    put(1, 16'h0111, 16'hB001);
    put(3, 16'h0333, 16'hB003);
    step();
    chk("t2_first", 32'(data_rcv), 32'b1000);
    wr_en[3] = 1'b0;
    step();
    chk("t2_second", 32'(data_rcv), 32'b0010);
    wr_en[1] = 1'b0;
    chk("t2_head_a", 32'(data_out[0 +: DW]), 32'hB003);
    rd_en[0] = 1'b1;
    step();
    chk("t2_head_b", 32'(data_out[0 +: DW]), 32'hB001);
    step();
    rd_en[0] = 1'b0;
    chk("t2_empty0", 32'(fifo_empty[0]), 32'd1);

    // Equal priorities: round-robin rotation onto destination 1.
    prio_val = '0; prio_wr = 1'b1;
    step();
    prio_wr = 1'b0;
    for (int i = 0; i < N; i++) put(i, 16'h1000 + 16'(i), 16'hC000 + 16'(i));
    for (int k = 0; k < N; k++) begin
      step();
      chk("t3_rotate", 32'(data_rcv), 32'(1 << k));
    end
    wr_en = '0;
    chk("t3_af1", 32'(fifo_af[1]), 32'd0);
    chk("t3_ae1", 32'(fifo_ae[1]), 32'd0);
    step();
    rd_en[1] = 1'b1;
    for (int k = 0; k < N; k++) begin
      chk("t3_order", 32'(data_out[DW +: DW]), 32'hC000 + 32'(k));
      step();
    end
    rd_en[1] = 1'b0;

    // Fill destination 2, then block a ninth request until a pop frees space.
    for (int k = 0; k < DEPTH; k++) begin
      put(0, 16'h2000 + 16'(k), 16'hD000 + 16'(k));
      step();
      wr_en[0] = 1'b0;
      chk("t4_af2", 32'(fifo_af[2]), 32'(k + 1 >= AF));
      chk("t4_full2", 32'(fifo_full[2]), 32'(k == DEPTH - 1));
      step();
    end
    put(0, 16'h2100, 16'hD0FF);
    repeat (3) begin
      step();
      chk("t4_blocked", 32'(data_rcv[0]), 32'd0);
    end
    rd_en[2] = 1'b1;
    step();
    rd_en[2] = 1'b0;
    chk("t4_pop_no_push", 32'(data_rcv[0]), 32'd0);
    chk("t4_not_full", 32'(fifo_full[2]), 32'd0);
    step();
    chk("t4_accept", 32'(data_rcv[0]), 32'd1);
    chk("t4_full_again", 32'(fifo_full[2]), 32'd1);
    wr_en[0] = 1'b0;
    rd_en[2] = 1'b1;
    repeat (DEPTH) step();
    rd_en[2] = 1'b0;
    chk("t4_drained", 32'(fifo_empty[2]), 32'd1);

    // Route table rewrite and unroutable drop.
    port_sel = 2'd1; port_addr = 4'hF; port_wr = 1'b1;
    step();
    port_wr = 1'b0;
    put(2, 16'hF000, 16'hE001);
    step();
    chk("t5_rcv", 32'(data_rcv[2]), 32'd1);
    chk("t5_nodrop", 32'(drop[2]), 32'd0);
    chk("t5_rdy1", 32'(data_rdy[1]), 32'd1);
    wr_en[2] = 1'b0;
    step();
    put(2, 16'h1000, 16'hE002);
    step();
    chk("t5_drop_rcv", 32'(data_rcv[2]), 32'd1);
    chk("t5_drop", 32'(drop[2]), 32'd1);
    chk("t5_head_kept", 32'(data_out[DW +: DW]), 32'hE001);
    wr_en[2] = 1'b0;
    step();
    port_en = 1'b0;
    put(2, 16'h1000, 16'hE003);
    rd_en[1] = 1'b1;
    step();
    rd_en[1] = 1'b0;
    step();
    chk("t5_disabled_nodrop", 32'(drop[2]), 32'd0);
    chk("t5_drain_while_off", 32'(fifo_empty[1]), 32'd1);
    wr_en[2] = 1'b0;
    port_en = 1'b1;

    // Asynchronous reset with queued entries and a pending request.
    for (int k = 0; k < 3; k++) begin
      put(3, 16'h3000 + 16'(k), 16'hA000 + 16'(k));
      step();
      wr_en[3] = 1'b0;
      step();
    end
    port_en = 1'b0;
    put(1, 16'h3555, 16'hA555);
    step();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    chk("t6_empty3", 32'(fifo_empty[3]), 32'd1);
    chk("t6_dout3", 32'(data_out[3*DW +: DW]), 32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;
    port_en = 1'b1;
    step();
    chk("t6_rcv1", 32'(data_rcv[1]), 32'd1);
    chk("t6_head3", 32'(data_out[3*DW +: DW]), 32'hA555);
    wr_en[1] = 1'b0;
    step();

    // Randomized traffic with random config updates.
    for (int c = 0; c < 400; c++) begin
      for (int s = 0; s < N; s++) begin
        if (rcv_m[s]) wr_en[s] = 1'b0;
        if (!wr_en[s] && $urandom_range(0, 2) == 0)
          put(s, {tags[$urandom_range(0, 5)], 12'($urandom)}, 16'($urandom));
      end
      for (int d = 0; d < N; d++)
        rd_en[d] = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 9) < 6);
      port_en   = ($urandom_range(0, 9) != 0);
      prio_wr   = ($urandom_range(0, 19) == 0);
      prio_val  = 8'($urandom);
      port_wr   = ($urandom_range(0, 29) == 0);
      port_sel  = 2'($urandom);
      port_addr = tags[$urandom_range(0, 4)];
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
